mux_rr_arbiter: RTL and testbench

Round-robin controller that shares the 4:1 gate-level multiplexer among four single-bit requesters. Drives the mux select lines (addr0/addr1) from a registered grant, then forwards the mux output downstream under a valid/ready handshake. Caps each grant at MAX_BEATS accepted beats for fairness. Sits between the requester bank and the structural mux; the mux itself stays external and unmodified.

---
 rtl/mux_rr_arbiter.sv | 130 +++++++++++++
 tb/tb_mux_rr_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that steers an external 4:1 mux and forwards its output under valid/ready.
// Optional macro MUX_RR_ARBITER_LOCK_EN adds a per-requester lock input that suspends the beat cap.
module mux_rr_arbiter #(
    parameter int MAX_BEATS = 4,
    parameter int CNT_W     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       mux_out,
    input  logic       out_ready,
`ifdef MUX_RR_ARBITER_LOCK_EN
    input  logic [3:0] lock,
`endif
    output logic       addr0,
    output logic       addr1,
    output logic [3:0] gnt,
    output logic       out_data,
    output logic       out_valid,
    output logic       busy
);

    // Handshake: a beat transfers on any rising edge where out_valid && out_ready;
    // out_valid only depends on state and req[owner], never on out_ready.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CAP      = CNT_W'(MAX_BEATS);
    localparam logic [CNT_W-1:0] CAP_LAST = CNT_W'(MAX_BEATS - 1);

    state_t           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       addr_q, addr_d;
    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       found;
    logic [1:0] winner;
    logic [1:0] idx;
    logic       rel;
    logic       locked;

`ifdef MUX_RR_ARBITER_LOCK_EN
    assign locked = lock[addr_q];
`else
    assign locked = 1'b0;
`endif

    always_comb begin
        found  = 1'b0;
        winner = 2'd0;
        idx    = 2'd0;
        // Scan last+1 .. last+4; the 2-bit sum wraps 3->0 on its own.
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        rel     = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = BUSY;
                    gnt_d   = 4'b0001 << winner;
                    addr_d  = winner;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (!req[addr_q]) begin
                    rel = 1'b1;
                end else if (out_ready) begin
                    // >= covers the saturated count left behind once lock is dropped.
                    if (!locked && cnt_q >= CAP_LAST) begin
                        rel = 1'b1;
                    end else if (cnt_q == CAP) begin
                        cnt_d = cnt_q;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (rel) begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            last_d  = addr_q;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            addr_q  <= 2'd0;
            last_q  <= 2'd3;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign addr0     = addr_q[0];
    assign addr1     = addr_q[1];
    assign gnt       = gnt_q;
    assign busy      = (state_q == BUSY);
    assign out_valid = (state_q == BUSY) && req[addr_q];
    assign out_data  = mux_out;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Randomized bench for mux_rr_arbiter with an abstract grant/beat model and directed literal checks.
module tb_mux_rr_arbiter;

  localparam int MB = 4;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic       mux_out;
  logic       out_ready;
  logic       addr0;
  logic       addr1;
  logic [3:0] gnt;
  logic       out_data;
  logic       out_valid;
  logic       busy;
  logic [3:0] in_data;
`ifdef MUX_RR_ARBITER_LOCK_EN
  logic [3:0] lock;
`endif

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  // reference model state
  bit m_busy;
  int m_owner;
  int m_addr;
  int m_last;
  int m_beats;

  mux_rr_arbiter #(.MAX_BEATS(MB), .CNT_W(3)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .mux_out(mux_out),
    .out_ready(out_ready),
`ifdef MUX_RR_ARBITER_LOCK_EN
    .lock(lock),
`endif
    .addr0(addr0),
    .addr1(addr1),
    .gnt(gnt),
    .out_data(out_data),
    .out_valid(out_valid),
    .busy(busy)
  );

  // stand-in for the external structural mux
  assign mux_out = in_data[{addr1, addr0}];

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #100 clk = ~clk;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model update at the active edge
  always @(posedge clk) begin
    bit lk;
`ifdef MUX_RR_ARBITER_LOCK_EN
    lk = lock[m_owner];
`else
    lk = 0;
`endif
    if (reset) begin
      m_busy = 0; m_addr = 0; m_last = 3; m_beats = 0; m_owner = 0;
    end else if (!m_busy) begin
      for (int k = 1; k <= 4; k++) begin
        int w;
        w = (m_last + k) % 4;
        if (!m_busy && req[w]) begin
          m_busy = 1; m_owner = w; m_addr = w; m_beats = 0;
        end
      end
    end else begin
      if (!req[m_owner]) begin
        m_busy = 0; m_last = m_owner; m_beats = 0;
      end else if (out_ready) begin
        m_beats = m_beats + 1;
        if (m_beats >= MB && !lk) begin
          m_busy = 0; m_last = m_owner; m_beats = 0;
        end
      end
    end
  end

  // scoreboard: compare every cycle on the falling edge
  always @(negedge clk) begin
    logic [3:0] e_gnt;
    logic       e_valid;
    if (chk_en) begin
      e_gnt   = m_busy ? (4'b0001 << m_owner) : 4'b0000;
      e_valid = m_busy && req[m_owner];
      chk("gnt", {4'b0, gnt}, {4'b0, e_gnt});
      chk("addr", {6'b0, addr1, addr0}, 8'(m_addr));
      chk("busy", {7'b0, busy}, {7'b0, m_busy});
      chk("out_valid", {7'b0, out_valid}, {7'b0, e_valid});
      if (e_valid) chk("out_data", {7'b0, out_data}, {7'b0, in_data[m_addr]});
    end
  end

  // driver: inputs change shortly after the active edge
  task automatic step(input logic rst, input logic [3:0] r, input logic rdy);
    @(posedge clk);
    #10;
    reset     = rst;
    req       = r;
    out_ready = rdy;
    in_data   = 4'($urandom_range(0, 15));
  endtask

  task automatic chk_lit(input string name, input logic [3:0] exp_gnt);
    @(negedge clk);
    chk(name, {4'b0, gnt}, {4'b0, exp_gnt});
  endtask

  initial begin
    logic [3:0] single_exp [7];
    reset = 1'b1; req = 4'b0; out_ready = 1'b0; in_data = 4'b0;
`ifdef MUX_RR_ARBITER_LOCK_EN
    lock = 4'b0;
`endif
    step(1'b1, 4'b0, 1'b0);
    chk_en = 1;
    step(1'b0, 4'b0, 1'b0);
    @(negedge clk);
    chk("reset_gnt", {4'b0, gnt}, 8'h00);
    chk("reset_busy", {7'b0, busy}, 8'h00);

    // single requester 2: four beats, one dead cycle, regrant
    single_exp = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0100};
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 4'b0100, 1'b1);
      chk_lit("single_gnt", single_exp[i]);
      if (i == 1) chk("single_addr", {6'b0, addr1, addr0}, 8'h02);
    end

    // reset mid-grant, then requester 0 wins (last reset to 3)
    step(1'b1, 4'b0100, 1'b1);
    step(1'b0, 4'b0001, 1'b1);
    chk_lit("mid_reset_gnt", 4'b0000);
    chk("mid_reset_valid", {7'b0, out_valid}, 8'h00);
    step(1'b0, 4'b0001, 1'b1);
    chk_lit("post_reset_gnt", 4'b0001);

    // round-robin wrap with all requesting
    step(1'b1, 4'b0000, 1'b1);
    for (int i = 0; i < 22; i++) begin
      logic [3:0] e;
      step(1'b0, 4'b1111, 1'b1);
      e = (i % 5 == 0) ? 4'b0000 : (4'b0001 << ((i / 5) % 4));
      chk_lit("rr_gnt", e);
    end

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic       rst;
      logic [3:0] r;
      rst = ($urandom_range(0, 199) == 0);
      r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r = 4'b0000;
`ifdef MUX_RR_ARBITER_LOCK_EN
      lock = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
`endif
      step(rst, r, 1'($urandom_range(0, 2) != 0));
    end

    step(1'b0, 4'b0000, 1'b0);
    @(negedge clk);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
